// File: rtl/occamy_cva6_pkg.sv
// Shared definitions for the CVA6 hart control block: register map regions,
// CTRL register layout, per-hart reset sequencer states and the default boot address.
package occamy_cva6_pkg;

    // Register map regions are selected by reg_addr[11:9]; hart index is reg_addr[8:3].
    localparam logic [2:0] RegionBoot  = 3'd0;
    localparam logic [2:0] RegionCtrl  = 3'd1;
    localparam logic [2:0] RegionMtime = 3'd2;
    localparam logic [2:0] RegionCmp   = 3'd3;

    localparam logic [63:0] BootAddrDefault = 64'h1_0000;

    // CTRL register: bit2 dbg, bit1 ipi, bit0 run.
    typedef struct packed {
        logic dbg;
        logic ipi;
        logic run;
    } hart_ctrl_t;

    typedef enum logic [1:0] {
        HartHeld,
        HartWait,
        HartRun
    } hart_state_e;

endpackage

// File: rtl/occamy_cva6_hart_ctrl_if.sv
// Configuration register bus between the SoC and the hart control block.
interface occamy_cva6_hart_ctrl_if;

    logic        reg_valid;
    logic        reg_ready;
    logic        reg_write;
    logic [11:0] reg_addr;
    logic [63:0] reg_wdata;
    logic        reg_rsp_valid;
    logic        reg_rsp_ready;
    logic [63:0] reg_rdata;
    logic        reg_error;

    modport master (
        output reg_valid, reg_write, reg_addr, reg_wdata, reg_rsp_ready,
        input  reg_ready, reg_rsp_valid, reg_rdata, reg_error
    );

    modport slave (
        input  reg_valid, reg_write, reg_addr, reg_wdata, reg_rsp_ready,
        output reg_ready, reg_rsp_valid, reg_rdata, reg_error
    );

endinterface

// File: rtl/occamy_cva6_hart_seq.sv
// Per-hart reset release sequencer: holds the core in reset until run is set,
// counts the hold time, then releases it with the boot address captured at release start.
module occamy_cva6_hart_seq
    import occamy_cva6_pkg::*;
#(
    parameter int unsigned ResetHoldCycles = 16,
    parameter logic [63:0] BootAddrReset   = BootAddrDefault
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        run_i,
    input  logic        ipi_i,
    input  logic        dbg_i,
    input  logic [63:0] boot_addr_i,
    output logic        core_rst_no,
    output logic [63:0] boot_addr_o,
    output logic        ipi_o,
    output logic        debug_req_o
);

    localparam int unsigned CntW = (ResetHoldCycles > 1) ? $clog2(ResetHoldCycles) : 1;

    hart_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0] boot_q, boot_d;

    // run_i is the value CTRL.run takes at this edge, so a clearing write
    // drops the hart to HELD on the same edge it lands.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        boot_d  = boot_q;
        case (state_q)
            HartHeld: begin
                if (run_i) begin
                    state_d = HartWait;
                    cnt_d   = '0;
                    boot_d  = boot_addr_i;
                end
            end
            HartWait: begin
                if (!run_i) begin
                    state_d = HartHeld;
                end else if (cnt_q == CntW'(ResetHoldCycles - 1)) begin
                    state_d = HartRun;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HartRun: begin
                if (!run_i) state_d = HartHeld;
            end
            default: state_d = HartHeld;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HartHeld;
            cnt_q   <= '0;
            boot_q  <= BootAddrReset;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            boot_q  <= boot_d;
        end
    end

    assign core_rst_no = (state_q == HartRun);
    assign boot_addr_o = boot_q;
    assign ipi_o       = ipi_i & (state_q != HartHeld);
    assign debug_req_o = dbg_i & (state_q != HartHeld);

endmodule

// File: rtl/occamy_cva6_hart_ctrl.sv
// Per-hart control for a group of CVA6 cores: config registers, reset sequencing,
// mtime/mtimecmp timer, IPI/debug requests and external IRQ synchronisation.
module occamy_cva6_hart_ctrl
    import occamy_cva6_pkg::*;
#(
    parameter int unsigned NrHarts         = 1,
    parameter int unsigned HartIdBase      = 0,
    parameter logic [63:0] BootAddrReset   = BootAddrDefault,
    parameter bit          AutoBootHart0   = 1'b1,
    parameter int unsigned ResetHoldCycles = 16,
    parameter int unsigned TimePrescale    = 1,
    parameter int unsigned SyncStages      = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    occamy_cva6_hart_ctrl_if.slave reg_bus,
    input  logic [NrHarts*2-1:0]   ext_irq_i,
    output logic [NrHarts-1:0]     core_rst_no,
    output logic [NrHarts*64-1:0]  boot_addr_o,
    output logic [NrHarts*64-1:0]  hart_id_o,
    output logic [NrHarts*2-1:0]   irq_o,
    output logic [NrHarts-1:0]     ipi_o,
    output logic [NrHarts-1:0]     time_irq_o,
    output logic [NrHarts-1:0]     debug_req_o
);

    localparam int unsigned PreW = (TimePrescale > 1) ? $clog2(TimePrescale) : 1;

    hart_ctrl_t  ctrl_q [NrHarts];
    hart_ctrl_t  ctrl_d [NrHarts];
    logic [63:0] boot_q [NrHarts];
    logic [63:0] boot_d [NrHarts];
    logic [63:0] cmp_q  [NrHarts];
    logic [63:0] cmp_d  [NrHarts];
    logic [63:0] mtime_q, mtime_d;
    logic [PreW-1:0] presc_q, presc_d;
    logic [NrHarts-1:0] tirq_q, tirq_d;
    logic [NrHarts*2-1:0] sync_q [SyncStages];
    logic [NrHarts*2-1:0] sync_d [SyncStages];
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic [2:0]  region;
    logic [5:0]  idx;
    logic        idx_ok, hit, accept, wr_en, tick;
    logic [63:0] rd;

    assign region  = reg_bus.reg_addr[11:9];
    assign idx     = reg_bus.reg_addr[8:3];
    assign idx_ok  = 32'(idx) < NrHarts;
    assign accept  = reg_bus.reg_valid & reg_bus.reg_ready;
    assign wr_en   = accept & reg_bus.reg_write & hit;

    always_comb begin
        hit = 1'b0;
        case (region)
            RegionBoot, RegionCtrl, RegionCmp: hit = idx_ok;
            RegionMtime:                       hit = (idx == '0);
            default:                           hit = 1'b0;
        endcase
        if (reg_bus.reg_addr[2:0] != 3'b000) hit = 1'b0;
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        boot_d      = boot_q;
        cmp_d       = cmp_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        rd          = '0;
        tick        = (presc_q == PreW'(TimePrescale - 1));
        presc_d     = tick ? '0 : presc_q + 1'b1;
        mtime_d     = mtime_q + {63'b0, tick};

        // A write to MTIME overrides the tick increment but leaves the prescaler running.
        if (region == RegionMtime) begin
            rd = mtime_q;
            if (wr_en) mtime_d = reg_bus.reg_wdata;
        end
        for (int unsigned h = 0; h < NrHarts; h++) begin
            if (32'(idx) == h) begin
                case (region)
                    RegionBoot: begin
                        rd = boot_q[h];
                        if (wr_en) boot_d[h] = reg_bus.reg_wdata;
                    end
                    RegionCtrl: begin
                        rd = {61'b0, ctrl_q[h]};
                        if (wr_en) ctrl_d[h] = hart_ctrl_t'(reg_bus.reg_wdata[2:0]);
                    end
                    RegionCmp: begin
                        rd = cmp_q[h];
                        if (wr_en) cmp_d[h] = reg_bus.reg_wdata;
                    end
                    default: ;
                endcase
            end
        end

        if (accept) begin
            rsp_valid_d = 1'b1;
            error_d     = !hit;
            rdata_d     = (hit && !reg_bus.reg_write) ? rd : '0;
        end else if (reg_bus.reg_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        for (int unsigned h = 0; h < NrHarts; h++) begin
            tirq_d[h] = (mtime_q >= cmp_q[h]);
        end

        sync_d[0] = ext_irq_i;
        for (int unsigned s = 1; s < SyncStages; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned h = 0; h < NrHarts; h++) begin
                ctrl_q[h]     <= '0;
                ctrl_q[h].run <= (h == 0) && AutoBootHart0;
                boot_q[h]     <= BootAddrReset;
                cmp_q[h]      <= '1;
            end
            for (int unsigned s = 0; s < SyncStages; s++) begin
                sync_q[s] <= '0;
            end
            mtime_q     <= '0;
            presc_q     <= '0;
            tirq_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            boot_q      <= boot_d;
            cmp_q       <= cmp_d;
            sync_q      <= sync_d;
            mtime_q     <= mtime_d;
            presc_q     <= presc_d;
            tirq_q      <= tirq_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
        end
    end

    assign reg_bus.reg_ready     = !rsp_valid_q || reg_bus.reg_rsp_ready;
    assign reg_bus.reg_rsp_valid = rsp_valid_q;
    assign reg_bus.reg_rdata     = rdata_q;
    assign reg_bus.reg_error     = error_q;
    assign irq_o                 = sync_q[SyncStages-1];
    assign time_irq_o            = tirq_q;

    for (genvar h = 0; h < NrHarts; h++) begin : g_hart
        assign hart_id_o[h*64 +: 64] = 64'(HartIdBase + h);

        occamy_cva6_hart_seq #(
            .ResetHoldCycles (ResetHoldCycles),
            .BootAddrReset   (BootAddrReset)
        ) i_seq (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .run_i       (ctrl_d[h].run),
            .ipi_i       (ctrl_q[h].ipi),
            .dbg_i       (ctrl_q[h].dbg),
            .boot_addr_i (boot_q[h]),
            .core_rst_no (core_rst_no[h]),
            .boot_addr_o (boot_addr_o[h*64 +: 64]),
            .ipi_o       (ipi_o[h]),
            .debug_req_o (debug_req_o[h])
        );
    end

endmodule

// File: tb/tb_occamy_cva6_hart_ctrl.sv
// Directed bench for occamy_cva6_hart_ctrl with four harts and a prescale of four.
module tb_occamy_cva6_hart_ctrl;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    occamy_cva6_hart_ctrl_if bus ();

    logic [7:0]   ext_irq;
    logic [3:0]   core_rst;
    logic [255:0] boot_addr;
    logic [255:0] hart_id;
    logic [7:0]   irq;
    logic [3:0]   ipi;
    logic [3:0]   time_irq;
    logic [3:0]   debug_req;

    int n_tests = 0;
    int n_fail  = 0;

    occamy_cva6_hart_ctrl #(
        .NrHarts         (4),
        .HartIdBase      (5),
        .BootAddrReset   (64'h1_0000),
        .AutoBootHart0   (1'b1),
        .ResetHoldCycles (16),
        .TimePrescale    (4),
        .SyncStages      (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .reg_bus     (bus),
        .ext_irq_i   (ext_irq),
        .core_rst_no (core_rst),
        .boot_addr_o (boot_addr),
        .hart_id_o   (hart_id),
        .irq_o       (irq),
        .ipi_o       (ipi),
        .time_irq_o  (time_irq),
        .debug_req_o (debug_req)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns 1ns after the accepting edge, with the response sampled.
    task automatic reg_xfer(input logic wr, input logic [11:0] addr, input logic [63:0] wdata,
                            output logic [63:0] rdata, output logic err);
        int unsigned n = 0;
        @(negedge clk);
        bus.reg_valid = 1'b1;
        bus.reg_write = wr;
        bus.reg_addr  = addr;
        bus.reg_wdata = wdata;
        while (!bus.reg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.reg_ready) check_eq("bus_ready_timeout", 64'(bus.reg_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.reg_valid = 1'b0;
        rdata = bus.reg_rdata;
        err   = bus.reg_error;
    endtask

    task automatic reg_wr(input logic [11:0] addr, input logic [63:0] wdata);
        logic [63:0] rdata;
        logic err;
        reg_xfer(1'b1, addr, wdata, rdata, err);
    endtask

    task automatic reg_rd(input logic [11:0] addr, output logic [63:0] rdata, output logic err);
        reg_xfer(1'b0, addr, 64'd0, rdata, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] rdata, held;
        logic err;
        int unsigned n;

        bus.reg_valid     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_addr      = '0;
        bus.reg_wdata     = '0;
        bus.reg_rsp_ready = 1'b1;
        ext_irq           = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_core_rst", 64'(core_rst), 64'h0);
        check_eq("rst_ready", 64'(bus.reg_ready), 64'h1);
        check_eq("rst_rsp_valid", 64'(bus.reg_rsp_valid), 64'h0);
        check_eq("rst_ipi_dbg", 64'({ipi, debug_req}), 64'h0);
        check_eq("rst_time_irq", 64'(time_irq), 64'h0);
        check_eq("rst_irq", 64'(irq), 64'h0);

        // Hart 0 self-releases 17 edges after reset deassertion.
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check_eq("hart0_still_held", 64'(core_rst), 64'h0);
        @(posedge clk);
        #1;
        check_eq("hart0_released", 64'(core_rst), 64'h1);
        check_eq("hart0_boot_addr", boot_addr[63:0], 64'h1_0000);
        check_eq("hart_id0", hart_id[63:0], 64'd5);
        check_eq("hart_id3", hart_id[255:192], 64'd8);

        // Hart 2 release with a programmed boot address.
        reg_wr(12'h010, 64'h8000_0000);
        reg_wr(12'h210, 64'h1);
        repeat (15) @(posedge clk);
        #1;
        check_eq("hart2_hold", 64'(core_rst[2]), 64'h0);
        @(posedge clk);
        #1;
        check_eq("hart2_release", 64'(core_rst[2]), 64'h1);
        check_eq("hart2_boot_addr", boot_addr[191:128], 64'h8000_0000);
        reg_wr(12'h010, 64'hdead_0000);
        check_eq("hart2_boot_stable", boot_addr[191:128], 64'h8000_0000);
        reg_rd(12'h010, rdata, err);
        check_eq("boot2_readback", rdata, 64'hdead_0000);

        // Hart 1 IPI and clearing run mid-RUN.
        reg_wr(12'h208, 64'h3);
        check_eq("hart1_ipi_set", 64'(ipi[1]), 64'h1);
        check_eq("hart1_in_wait", 64'(core_rst[1]), 64'h0);
        repeat (16) @(posedge clk);
        #1;
        check_eq("hart1_release", 64'(core_rst[1]), 64'h1);
        reg_wr(12'h208, 64'h0);
        check_eq("hart1_rst_drop", 64'(core_rst[1]), 64'h0);
        check_eq("hart1_ipi_clear", 64'(ipi[1]), 64'h0);

        // Hart 3: debug gated while held, then run restart mid-WAIT.
        reg_wr(12'h218, 64'h4);
        check_eq("hart3_dbg_held", 64'(debug_req[3]), 64'h0);
        reg_wr(12'h218, 64'h5);
        check_eq("hart3_dbg_set", 64'(debug_req[3]), 64'h1);
        check_eq("hart3_ipi_off", 64'(ipi[3]), 64'h0);
        repeat (5) @(posedge clk);
        reg_wr(12'h218, 64'h0);
        check_eq("hart3_dbg_clear", 64'(debug_req[3]), 64'h0);
        reg_wr(12'h218, 64'h1);
        repeat (15) @(posedge clk);
        #1;
        check_eq("hart3_restart_hold", 64'(core_rst[3]), 64'h0);
        @(posedge clk);
        #1;
        check_eq("hart3_restart_release", 64'(core_rst[3]), 64'h1);

        // Unmapped accesses.
        reg_rd(12'h228, rdata, err);
        check_eq("err_rd_ctrl4_flag", 64'(err), 64'h1);
        check_eq("err_rd_ctrl4_data", rdata, 64'h0);
        reg_wr(12'h7F8, 64'h1234);
        reg_rd(12'h618, rdata, err);
        check_eq("cmp3_untouched", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("cmp3_no_err", 64'(err), 64'h0);
        reg_xfer(1'b1, 12'h7F8, 64'h1234, rdata, err);
        check_eq("err_wr_7f8_flag", 64'(err), 64'h1);

        // Response backpressure.
        repeat (2) @(negedge clk);
        bus.reg_rsp_ready = 1'b0;
        bus.reg_valid     = 1'b1;
        bus.reg_write     = 1'b0;
        bus.reg_addr      = 12'h600;
        @(posedge clk);
        #1;
        bus.reg_valid = 1'b0;
        held = bus.reg_rdata;
        check_eq("bp_rdata", held, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_ready_low", 64'(bus.reg_ready), 64'h0);
            check_eq("bp_rsp_valid", 64'(bus.reg_rsp_valid), 64'h1);
            check_eq("bp_rdata_stable", bus.reg_rdata, held);
        end
        bus.reg_rsp_ready = 1'b1;
        #1;
        check_eq("bp_ready_back", 64'(bus.reg_ready), 64'h1);
        @(posedge clk);
        #1;
        check_eq("bp_rsp_drained", 64'(bus.reg_rsp_valid), 64'h0);

        // Timer compare, then MTIME wrap.
        reg_wr(12'h400, 64'h0);
        reg_wr(12'h608, 64'd10);
        n = 0;
        while (!time_irq[1] && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("tirq_rise_window", 64'((n >= 36) && (n <= 42)), 64'h1);
        reg_rd(12'h400, rdata, err);
        check_eq("mtime_at_rise", rdata, 64'd10);
        check_eq("tirq_other_low", 64'(time_irq[0]), 64'h0);
        reg_wr(12'h400, 64'hFFFF_FFFF_FFFF_FFFF);
        n = 0;
        while (time_irq[1] && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("tirq_fall_after_wrap", 64'(time_irq[1]), 64'h0);
        reg_rd(12'h400, rdata, err);
        check_eq("mtime_wrapped", rdata, 64'h0);
        reg_wr(12'h608, 64'h0);
        check_eq("tirq_lag", 64'(time_irq[1]), 64'h0);
        @(posedge clk);
        #1;
        check_eq("tirq_after_lag", 64'(time_irq[1]), 64'h1);

        // External IRQ synchroniser latency.
        @(negedge clk);
        ext_irq = 8'h08;
        @(posedge clk);
        #1;
        check_eq("irq_sync_1", 64'(irq), 64'h00);
        @(posedge clk);
        #1;
        check_eq("irq_sync_2", 64'(irq), 64'h08);
        @(negedge clk);
        ext_irq = 8'h00;
        @(posedge clk);
        #1;
        check_eq("irq_fall_1", 64'(irq), 64'h08);
        @(posedge clk);
        #1;
        check_eq("irq_fall_2", 64'(irq), 64'h00);

        // Reset asserted while hart 1 is in WAIT.
        reg_wr(12'h208, 64'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_core_rst", 64'(core_rst), 64'h0);
        check_eq("mid_rst_boot2", boot_addr[191:128], 64'h1_0000);
        check_eq("mid_rst_ipi_dbg", 64'({ipi, debug_req}), 64'h0);
        check_eq("mid_rst_time_irq", 64'(time_irq), 64'h0);
        check_eq("mid_rst_ready", 64'(bus.reg_ready), 64'h1);
        check_eq("mid_rst_rsp_valid", 64'(bus.reg_rsp_valid), 64'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        reg_rd(12'h400, rdata, err);
        check_eq("post_rst_mtime", rdata, 64'h0);
        reg_rd(12'h208, rdata, err);
        check_eq("post_rst_ctrl1", rdata, 64'h0);
        reg_rd(12'h200, rdata, err);
        check_eq("post_rst_ctrl0", rdata, 64'h1);
        reg_rd(12'h600, rdata, err);
        check_eq("post_rst_cmp0", rdata, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
